// File: rtl/tim_apb_arbiter_if.sv
// ============================================================================
// Module      : tim_apb_arbiter_if
// Description : Requester handshakes plus timer APB bus seen by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tim_apb_arbiter_if #(
    parameter int AW = 12
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [31:0]   wdata0;
    logic [31:0]   wdata1;
    logic          ack0;
    logic          ack1;
    logic          err0;
    logic          err1;
    logic [31:0]   rdata0;
    logic [31:0]   rdata1;
    logic          tim_psel;
    logic          tim_penable;
    logic          tim_pwrite;
    logic [AW-1:0] tim_paddr;
    logic [31:0]   tim_pwdata;
    logic          tim_pready;
    logic [31:0]   tim_prdata;
    logic          busy;

    modport master (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata,
        input  tim_pready, tim_prdata,
        output busy
    );

    modport slave (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata,
        output tim_pready, tim_prdata,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/tim_apb_arbiter.sv
// ============================================================================
// Module      : tim_apb_arbiter
// Description : Round-robin two-requester APB master for the timer slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tim_apb_arbiter #(
    parameter int AW      = 12,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  wire                  sys_clk,
    input  wire                  sys_rst_n,
    tim_apb_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state_q;
    logic          gnt_q;
    logic          last_q;
    logic [TW-1:0] cnt_q;
    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [AW-1:0] paddr_q;
    logic [31:0]   pwdata_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          err0_q;
    logic          err1_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;
    logic          busy_q;

    logic          elig0_d;
    logic          elig1_d;
    logic          win_d;
    logic          expire_d;

    // A requester whose ack is on the bus this cycle is dropping its request.
    always_comb begin
        elig0_d  = bus.req0 & ~ack0_q;
        elig1_d  = bus.req1 & ~ack1_q;
        win_d    = (elig0_d & elig1_d) ? ~last_q : elig1_d;
        expire_d = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (elig0_d | elig1_d) begin
                        gnt_q    <= win_d;
                        last_q   <= win_d;
                        pwrite_q <= win_d ? bus.we1    : bus.we0;
                        paddr_q  <= win_d ? bus.addr1  : bus.addr0;
                        pwdata_q <= win_d ? bus.wdata1 : bus.wdata0;
                        psel_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A pready arriving on the expiry edge still counts as success.
                    if (bus.tim_pready || expire_d) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                        if (gnt_q) begin
                            ack1_q <= 1'b1;
                            err1_q <= ~bus.tim_pready;
                            if (!bus.tim_pready) begin
                                rdata1_q <= '0;
                            end else if (!pwrite_q) begin
                                rdata1_q <= bus.tim_prdata;
                            end
                        end else begin
                            ack0_q <= 1'b1;
                            err0_q <= ~bus.tim_pready;
                            if (!bus.tim_pready) begin
                                rdata0_q <= '0;
                            end else if (!pwrite_q) begin
                                rdata0_q <= bus.tim_prdata;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.err0        = err0_q;
    assign bus.err1        = err1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.tim_psel    = psel_q;
    assign bus.tim_penable = penable_q;
    assign bus.tim_pwrite  = pwrite_q;
    assign bus.tim_paddr   = paddr_q;
    assign bus.tim_pwdata  = pwdata_q;
    assign bus.busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_tim_apb_arbiter.sv
// ============================================================================
// Module      : tb_tim_apb_arbiter
// Description : Self-checking bench for tim_apb_arbiter against a transfer-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tim_apb_arbiter;

    localparam int AW      = 12;
    localparam int TIMEOUT = 16;
    localparam int TW      = 5;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    tim_apb_arbiter_if #(.AW(AW)) bus ();

    tim_apb_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int          total = 0;
    int          fails = 0;
    logic [31:0] mdl_rdata [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic we,
                           input logic [AW-1:0] addr, input logic [31:0] wd);
        if (id == 0) begin
            bus.req0 = v; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end else begin
            bus.req1 = v; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end
    endtask

    function automatic logic ack_of(input int id);
        return (id == 0) ? bus.ack0 : bus.ack1;
    endfunction

    function automatic logic err_of(input int id);
        return (id == 0) ? bus.err0 : bus.err1;
    endfunction

    // One isolated transfer from an idle arbiter; slave waits 'waits' ACCESS cycles.
    task automatic do_xfer(input int id, input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd);
        logic exp_err;
        int   n_acc;
        exp_err = (TIMEOUT > 0) && (waits + 1 > TIMEOUT);
        n_acc   = exp_err ? TIMEOUT : waits + 1;
        set_req(id, 1'b1, we, addr, wd);
        bus.tim_prdata = rd;
        bus.tim_pready = 1'b0;
        @(negedge sys_clk);
        chk("setup_psel", bus.tim_psel, 1'b1);
        chk("setup_penable", bus.tim_penable, 1'b0);
        chk("setup_pwrite", bus.tim_pwrite, we);
        chk("setup_paddr", bus.tim_paddr, addr);
        if (we) chk("setup_pwdata", bus.tim_pwdata, wd);
        chk("setup_busy", bus.busy, 1'b1);
        for (int a = 1; a <= n_acc; a++) begin
            @(negedge sys_clk);
            chk("access_psel", bus.tim_psel, 1'b1);
            chk("access_penable", bus.tim_penable, 1'b1);
            chk("access_busy", bus.busy, 1'b1);
            chk("access_noack", {bus.ack1, bus.ack0}, 2'b00);
            bus.tim_pready = (a == waits + 1);
        end
        @(negedge sys_clk);
        bus.tim_pready = 1'b0;
        set_req(id, 1'b0, we, addr, wd);
        if (exp_err)  mdl_rdata[id] = '0;
        else if (!we) mdl_rdata[id] = rd;
        chk("ack", ack_of(id), 1'b1);
        chk("ack_other", ack_of(1 - id), 1'b0);
        chk("err", err_of(id), exp_err);
        chk("rdata0", bus.rdata0, mdl_rdata[0]);
        chk("rdata1", bus.rdata1, mdl_rdata[1]);
        chk("ackcyc_psel", {bus.tim_psel, bus.tim_penable, bus.busy}, 3'b000);
        chk("ackcyc_paddr_hold", bus.tim_paddr, addr);
        @(negedge sys_clk);
        chk("post_ack_pulse", {bus.ack1, bus.ack0}, 2'b00);
        chk("post_idle", {bus.tim_psel, bus.busy}, 2'b00);
    endtask

    initial begin
        int gq[$];
        int aq[$];
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        bus.tim_pready = 1'b0;
        bus.tim_prdata = '0;

        // Reset state
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_bus", {bus.tim_psel, bus.tim_penable, bus.tim_pwrite, bus.busy}, 4'h0);
        chk("rst_ack", {bus.ack0, bus.ack1, bus.err0, bus.err1}, 4'h0);
        chk("rst_paddr", bus.tim_paddr, '0);
        chk("rst_rdata0", bus.rdata0, '0);
        sys_rst_n = 1'b1;

        // Contention straight after reset, requests held, zero-wait slave
        set_req(0, 1'b1, 1'b1, 12'h100, 32'hDEAD_0000);
        set_req(1, 1'b1, 1'b0, 12'h200, 32'h0);
        bus.tim_pready = 1'b1;
        bus.tim_prdata = 32'hC0DE_0001;
        for (int c = 0; c < 40 && aq.size() < 4; c++) begin
            @(negedge sys_clk);
            if (bus.tim_psel && !bus.tim_penable) gq.push_back((bus.tim_paddr == 12'h200) ? 1 : 0);
            if (bus.ack0) aq.push_back(0);
            if (bus.ack1) aq.push_back(1);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        bus.tim_pready = 1'b0;
        mdl_rdata[1] = 32'hC0DE_0001;
        chk("cont_grants", gq.size(), 4);
        chk("cont_acks", aq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_grant_id", (i < gq.size()) ? gq[i] : -1, i % 2);
            chk("cont_ack_id", (i < aq.size()) ? aq[i] : -1, i % 2);
        end
        chk("cont_rdata1", bus.rdata1, mdl_rdata[1]);
        @(negedge sys_clk);
        chk("cont_idle", bus.busy, 1'b0);

        // Held request is ignored in its own ack cycle
        set_req(0, 1'b1, 1'b0, 12'h0C0, 32'h0);
        bus.tim_pready = 1'b1;
        bus.tim_prdata = 32'h5A5A_0C0C;
        @(negedge sys_clk);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("mask_ack", bus.ack0, 1'b1);
        @(negedge sys_clk);
        chk("mask_no_regrant", {bus.tim_psel, bus.busy}, 2'b00);
        @(negedge sys_clk);
        chk("mask_regrant", bus.tim_psel, 1'b1);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("mask_ack2", bus.ack0, 1'b1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        bus.tim_pready = 1'b0;
        mdl_rdata[0] = 32'h5A5A_0C0C;
        chk("mask_rdata0", bus.rdata0, mdl_rdata[0]);
        @(negedge sys_clk);

        // Directed write and read with a one-wait slave
        do_xfer(0, 1'b1, 12'h004, 32'hA5A5_0001, 1, 32'hFFFF_FFFF);
        do_xfer(1, 1'b0, 12'h010, 32'h0, 1, 32'h1234_5678);

        // Randomized transfers
        for (int n = 0; n < 14; n++) begin
            int w;
            w = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
            do_xfer($urandom_range(0, 1), 1'($urandom), AW'($urandom), $urandom, w, $urandom);
        end

        // Timeout, recovery, and expiry tie
        do_xfer(0, 1'b0, 12'h008, 32'h0, TIMEOUT + 4, 32'h7777_7777);
        do_xfer(0, 1'b0, 12'h00C, 32'h0, 1, 32'h0BAD_CAFE);
        do_xfer(0, 1'b0, 12'h00C, 32'h0, TIMEOUT - 1, 32'h1111_2222);
        do_xfer(1, 1'b1, 12'h014, 32'h3333_4444, TIMEOUT, 32'h0);

        // Asynchronous reset while in ACCESS
        set_req(0, 1'b1, 1'b0, 12'h0F0, 32'h0);
        bus.tim_pready = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rstacc_penable", bus.tim_penable, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        chk("rstacc_bus", {bus.tim_psel, bus.tim_penable, bus.tim_pwrite, bus.busy}, 4'h0);
        chk("rstacc_ack", {bus.ack0, bus.ack1, bus.err0, bus.err1}, 4'h0);
        chk("rstacc_paddr", bus.tim_paddr, '0);
        chk("rstacc_pwdata", bus.tim_pwdata, '0);
        chk("rstacc_rdata0", bus.rdata0, mdl_rdata[0]);
        chk("rstacc_rdata1", bus.rdata1, mdl_rdata[1]);
        @(negedge sys_clk);
        chk("rstacc_held", {bus.tim_psel, bus.ack0}, 2'b00);
        sys_rst_n      = 1'b1;
        bus.tim_pready = 1'b1;
        bus.tim_prdata = 32'hFEED_F00D;
        @(negedge sys_clk);
        chk("rstacc_setup", {bus.tim_psel, bus.tim_penable}, 2'b10);
        chk("rstacc_paddr2", bus.tim_paddr, 12'h0F0);
        @(negedge sys_clk);
        chk("rstacc_access", bus.tim_penable, 1'b1);
        @(negedge sys_clk);
        mdl_rdata[0] = 32'hFEED_F00D;
        chk("rstacc_ack0", bus.ack0, 1'b1);
        chk("rstacc_err0", bus.err0, 1'b0);
        chk("rstacc_rdata0b", bus.rdata0, mdl_rdata[0]);
        set_req(0, 1'b0, 1'b0, '0, '0);
        bus.tim_pready = 1'b0;
        @(negedge sys_clk);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

`default_nettype wire
